// File: rtl/i2s_pkg.sv
// Shared types and defaults for the clock-slave I2S transmitter.
package i2s_pkg;

  localparam int unsigned I2S_DATA_W = 24;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } tx_state_e;

  // Stereo sample pair at the default sample width.
  typedef struct packed {
    logic [I2S_DATA_W-1:0] l;
    logic [I2S_DATA_W-1:0] r;
  } sample_pair_t;

endpackage

// File: rtl/i2s_edge_sync.sv
// Synchronizer for an external clock-like input: SYNC_STAGES flops, one
// history flop, and registered single-cycle rise/fall pulses.
// level_o is the history flop, so it lines up with the rise/fall pulses.
module i2s_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise_q;
  logic                   fall_q;

  // Shift the pin through the synchronizer and flag edges against history.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      hist_q <= sync_q[SYNC_STAGES-1];
      rise_q <= ~hist_q & sync_q[SYNC_STAGES-1];
      fall_q <= hist_q & ~sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = hist_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2s_slave_tx.sv
// Clock-slave I2S transmitter: oversamples external sclk/lrclk on clk and
// shifts stereo samples out MSB-first with the one-bit I2S delay.
// Optional: define I2S_SLAVE_TX_REPEAT_ON_UNDERRUN_EN to resend the last
// pair on underrun instead of sending zeros.
module i2s_slave_tx
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W      = I2S_DATA_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_in,
  input  logic              lrclk_in,
  input  logic [DATA_W-1:0] in_ldata,
  input  logic [DATA_W-1:0] in_rdata,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sdout,
  output logic              underrun,
  output logic              locked
);

  logic sclk_fall;
  logic sclk_rise;
  logic sclk_lvl;
  logic lr_s;
  logic lr_rise;
  logic lr_fall;
  logic unused_edges;

  i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (sclk_in),
    .level_o (sclk_lvl),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lr_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (lrclk_in),
    .level_o (lr_s),
    .rise_o  (lr_rise),
    .fall_o  (lr_fall)
  );

  // lrclk is judged against lr_prev_q on sclk falls, not by its own edges.
  assign unused_edges = sclk_rise ^ sclk_lvl ^ lr_rise ^ lr_fall;

  tx_state_e         state_q;
  logic              lr_prev_q;
  logic              full_q;
  logic [DATA_W-1:0] buf_l_q;
  logic [DATA_W-1:0] buf_r_q;
  logic [DATA_W-1:0] act_l_q;
  logic [DATA_W-1:0] act_r_q;
  logic [DATA_W-1:0] act_l_d;
  logic [DATA_W-1:0] act_r_d;
  logic [DATA_W-1:0] shift_q;
  logic              sdout_q;
  logic              underrun_q;
  logic              wr_en;
  logic              left_start;
  logic              right_start;

  assign wr_en       = in_valid & ~full_q;
  assign left_start  = sclk_fall & lr_prev_q & ~lr_s;
  assign right_start = sclk_fall & ~lr_prev_q & lr_s;

  // Active pair for the frame: taken from the buffer at a left start,
  // or replaced on underrun.
  always_comb begin
    act_l_d = act_l_q;
    act_r_d = act_r_q;
    if (left_start) begin
      if (full_q) begin
        act_l_d = buf_l_q;
        act_r_d = buf_r_q;
      end else begin
`ifdef I2S_SLAVE_TX_REPEAT_ON_UNDERRUN_EN
        act_l_d = act_l_q;
        act_r_d = act_r_q;
`else
        act_l_d = '0;
        act_r_d = '0;
`endif
      end
    end
  end

  // Lock FSM, holding buffer and output shifter, all advanced on sclk falls.
  // The consume path reads the pre-cycle full flag; a write can only land
  // when that flag was clear, so the two never fight over full_q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= UNLOCKED;
      lr_prev_q  <= 1'b0;
      full_q     <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      act_l_q    <= '0;
      act_r_q    <= '0;
      shift_q    <= '0;
      sdout_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      act_l_q    <= act_l_d;
      act_r_q    <= act_r_d;
      if (sclk_fall) begin
        lr_prev_q <= lr_s;
        if (left_start) begin
          if (full_q) begin
            full_q <= 1'b0;
          end else begin
            underrun_q <= 1'b1;
          end
          shift_q <= act_l_d;
          sdout_q <= 1'b0;
          state_q <= LOCKED;
        end else if (state_q == LOCKED) begin
          if (right_start) begin
            shift_q <= act_r_q;
            sdout_q <= 1'b0;
          end else begin
            sdout_q <= shift_q[DATA_W-1];
            shift_q <= {shift_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      if (wr_en) begin
        buf_l_q <= in_ldata;
        buf_r_q <= in_rdata;
        full_q  <= 1'b1;
      end
    end
  end

  assign in_ready = ~full_q;
  assign sdout    = sdout_q;
  assign underrun = underrun_q;
  assign locked   = (state_q == LOCKED);

endmodule

// File: tb/tb_i2s_slave_tx.sv
// Directed bench for i2s_slave_tx: the bench plays I2S master on the pins
// (sclk half period = 16 clk) and samples sdout on sclk rising edges.
module tb_i2s_slave_tx;
  import i2s_pkg::*;

  localparam int unsigned DW = I2S_DATA_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          sclk_in;
  logic          lrclk_in;
  logic [DW-1:0] in_ldata;
  logic [DW-1:0] in_rdata;
  logic          in_valid;
  logic          in_ready;
  logic          sdout;
  logic          underrun;
  logic          locked;

  int checks   = 0;
  int failures = 0;
  int urun_cnt = 0;

  logic          bp_en       = 1'b0;
  logic [DW-1:0] bp_val      = '0;
  logic          acc_pending = 1'b0;
  int            acc_cnt     = 0;

  logic          coin_arm = 1'b0;
  sample_pair_t  coin_pair;
  logic          pre_urun, pre_lock, post_urun, post_lock, post_ready;

  logic [DW-1:0] last_l, last_r;

  always #5 clk = ~clk;

  i2s_slave_tx #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk_in  (sclk_in),
    .lrclk_in (lrclk_in),
    .in_ldata (in_ldata),
    .in_rdata (in_rdata),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sdout    (sdout),
    .underrun (underrun),
    .locked   (locked)
  );

  function automatic logic [31:0] exp32(input logic [DW-1:0] d);
    return {1'b0, d, 7'b0};
  endfunction

  function automatic logic [31:0] exp20(input logic [DW-1:0] d);
    return {12'b0, 1'b0, d[23:5]};
  endfunction

  // One clk step (ends on a negedge); k is the clk index within the sclk bit.
  task automatic tick(input int k);
    @(negedge clk);
    if (underrun) urun_cnt++;
    if (bp_en) begin
      if (acc_pending) begin
        bp_val++;
        acc_cnt++;
      end
      in_valid    = 1'b1;
      in_ldata    = bp_val | 24'hF00000;
      in_rdata    = bp_val + 24'h100000;
      acc_pending = in_ready;
    end
    if (coin_arm && k == 2) begin
      pre_urun = underrun;
      pre_lock = locked;
      in_valid = 1'b1;
      in_ldata = coin_pair.l;
      in_rdata = coin_pair.r;
    end
    if (coin_arm && k == 3) begin
      post_urun  = underrun;
      post_lock  = locked;
      post_ready = in_ready;
      in_valid   = 1'b0;
      coin_arm   = 1'b0;
    end
  endtask

  // One sclk period: fall (with lrclk update), then sample sdout at the rise.
  task automatic sbit(input logic lr, output logic b);
    sclk_in  = 1'b0;
    lrclk_in = lr;
    for (int k = 0; k < 16; k++) tick(k);
    b       = sdout;
    sclk_in = 1'b1;
    for (int k = 16; k < 32; k++) tick(k);
  endtask

  task automatic slot(input logic lr, input int n, output logic [31:0] cap);
    logic b;
    cap = '0;
    for (int i = 0; i < n; i++) begin
      sbit(lr, b);
      cap = {cap[30:0], b};
    end
  endtask

  task automatic load(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick(-1);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL load_wait in_ready=%b expected=1", in_ready);
    end
    in_valid = 1'b1;
    in_ldata = l;
    in_rdata = r;
    tick(-1);
    in_valid = 1'b0;
    last_l   = l;
    last_r   = r;
  endtask

  task automatic test_reset;
    rst      = 1'b0;
    sclk_in  = 1'b1;
    lrclk_in = 1'b1;
    in_valid = 1'b0;
    in_ldata = '0;
    in_rdata = '0;
    repeat (4) @(negedge clk);
    checks++; if (sdout !== 1'b0)    begin failures++; $display("FAIL reset_sdout got=%b exp=0", sdout); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    checks++; if (locked !== 1'b0)   begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
    rst = 1'b1;
    tick(-1);
  endtask

  task automatic test_lock;
    logic [31:0] cap;
    load(24'hA5F00F, 24'h800001);
    slot(1'b1, 8, cap);
    checks++; if (cap !== 32'h0)    begin failures++; $display("FAIL lock_sdout_idle got=%h exp=0", cap); end
    checks++; if (locked !== 1'b0)  begin failures++; $display("FAIL lock_before_left got=%b exp=0", locked); end
  endtask

  task automatic test_basic;
    logic [31:0] capl, capr;
    slot(1'b0, 32, capl);
    slot(1'b1, 32, capr);
    checks++; if (capl !== exp32(24'hA5F00F)) begin failures++; $display("FAIL basic_left got=%h exp=%h", capl, exp32(24'hA5F00F)); end
    checks++; if (capr !== exp32(24'h800001)) begin failures++; $display("FAIL basic_right got=%h exp=%h", capr, exp32(24'h800001)); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
    checks++; if (locked !== 1'b1)   begin failures++; $display("FAIL basic_locked got=%b exp=1", locked); end
  endtask

  task automatic test_underrun;
    logic [31:0] capl, capr, el, er;
    int u0;
`ifdef I2S_SLAVE_TX_REPEAT_ON_UNDERRUN_EN
    el = exp32(last_l);
    er = exp32(last_r);
`else
    el = 32'h0;
    er = 32'h0;
`endif
    u0 = urun_cnt;
    for (int f = 0; f < 2; f++) begin
      slot(1'b0, 32, capl);
      slot(1'b1, 32, capr);
      checks++; if (capl !== el) begin failures++; $display("FAIL underrun_left f=%0d got=%h exp=%h", f, capl, el); end
      checks++; if (capr !== er) begin failures++; $display("FAIL underrun_right f=%0d got=%h exp=%h", f, capr, er); end
    end
    checks++; if (urun_cnt - u0 !== 2) begin failures++; $display("FAIL underrun_pulses got=%0d exp=2", urun_cnt - u0); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] capl, capr;
    logic [DW-1:0] el, er;
    bp_val      = 24'd1;
    acc_cnt     = 0;
    acc_pending = 1'b0;
    bp_en       = 1'b1;
    for (int f = 0; f < 3; f++) begin
      slot(1'b0, 32, capl);
      slot(1'b1, 32, capr);
      el = DW'(f + 1) | 24'hF00000;
      er = DW'(f + 1) + 24'h100000;
      checks++; if (capl !== exp32(el)) begin failures++; $display("FAIL b2b_left f=%0d got=%h exp=%h", f, capl, exp32(el)); end
      checks++; if (capr !== exp32(er)) begin failures++; $display("FAIL b2b_right f=%0d got=%h exp=%h", f, capr, exp32(er)); end
    end
    bp_en    = 1'b0;
    in_valid = 1'b0;
    checks++; if (acc_cnt !== 4) begin failures++; $display("FAIL b2b_accepts got=%0d exp=4", acc_cnt); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] cap;
    // Frame carries F00004: delay bit, then 1,1 for the first two data bits.
    slot(1'b0, 3, cap);
    checks++; if (cap[2:0] !== 3'b011) begin failures++; $display("FAIL rstmid_prefix got=%b exp=011", cap[2:0]); end
    checks++; if (sdout !== 1'b1)      begin failures++; $display("FAIL rstmid_sdout_before got=%b exp=1", sdout); end
    rst = 1'b0;
    tick(-1);
    checks++; if (sdout !== 1'b0)  begin failures++; $display("FAIL rstmid_sdout got=%b exp=0", sdout); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rstmid_locked got=%b exp=0", locked); end
    tick(-1);
    rst = 1'b1;
    tick(-1);
  endtask

  task automatic test_coincident;
    logic [31:0] capl, capr;
    int u0;
    slot(1'b0, 4, capl);
    slot(1'b1, 32, capr);
    coin_pair.l = 24'hC0FFEE;
    coin_pair.r = 24'h5A5A5A;
    u0       = urun_cnt;
    coin_arm = 1'b1;
    slot(1'b0, 32, capl);
    slot(1'b1, 32, capr);
    checks++; if (pre_urun !== 1'b0)   begin failures++; $display("FAIL coin_pre_underrun got=%b exp=0", pre_urun); end
    checks++; if (pre_lock !== 1'b0)   begin failures++; $display("FAIL coin_pre_locked got=%b exp=0", pre_lock); end
    checks++; if (post_urun !== 1'b1)  begin failures++; $display("FAIL coin_underrun got=%b exp=1", post_urun); end
    checks++; if (post_lock !== 1'b1)  begin failures++; $display("FAIL coin_locked got=%b exp=1", post_lock); end
    checks++; if (post_ready !== 1'b0) begin failures++; $display("FAIL coin_in_ready got=%b exp=0", post_ready); end
    checks++; if (capl !== 32'h0) begin failures++; $display("FAIL coin_left0 got=%h exp=0", capl); end
    checks++; if (capr !== 32'h0) begin failures++; $display("FAIL coin_right0 got=%h exp=0", capr); end
    checks++; if (urun_cnt - u0 !== 1) begin failures++; $display("FAIL coin_pulses got=%0d exp=1", urun_cnt - u0); end
    slot(1'b0, 32, capl);
    slot(1'b1, 32, capr);
    checks++; if (capl !== exp32(24'hC0FFEE)) begin failures++; $display("FAIL coin_left1 got=%h exp=%h", capl, exp32(24'hC0FFEE)); end
    checks++; if (capr !== exp32(24'h5A5A5A)) begin failures++; $display("FAIL coin_right1 got=%h exp=%h", capr, exp32(24'h5A5A5A)); end
  endtask

  task automatic test_short_slot;
    logic [31:0] capl, capr, capl2, capr2;
    load(24'hABCDEF, 24'h13579B);
    slot(1'b0, 20, capl);
    load(24'h2468AC, 24'hFEDCBA);
    slot(1'b1, 20, capr);
    slot(1'b0, 20, capl2);
    slot(1'b1, 20, capr2);
    checks++; if (capl !== exp20(24'hABCDEF))  begin failures++; $display("FAIL short_left0 got=%h exp=%h", capl, exp20(24'hABCDEF)); end
    checks++; if (capr !== exp20(24'h13579B))  begin failures++; $display("FAIL short_right0 got=%h exp=%h", capr, exp20(24'h13579B)); end
    checks++; if (capl2 !== exp20(24'h2468AC)) begin failures++; $display("FAIL short_left1 got=%h exp=%h", capl2, exp20(24'h2468AC)); end
    checks++; if (capr2 !== exp20(24'hFEDCBA)) begin failures++; $display("FAIL short_right1 got=%h exp=%h", capr2, exp20(24'hFEDCBA)); end
  endtask

  initial begin
    test_reset;
    test_lock;
    test_basic;
    test_underrun;
    test_back_to_back;
    test_reset_mid;
    test_coincident;
    test_short_slot;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
